// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//
// Inter-stage pipeline register with ready/valid flow control and a 2-entry
// skid buffer. Control and datapath fields travel as two packed vectors so
// one block serves every stage boundary (decode/execute/memory/writeback).
// Control bits are zeroed whenever the stage holds no entry, so downstream
// always sees a NOP on a bubble. Datapath bits are only cleared by Reset.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add a saturating 16-bit
// stall counter (cycles with out_valid=1 and out_ready=0) on port
// stall_cycles. Flow behaviour is identical with or without it.
//
// Parameters:
//   CTRL_W        width of the control vector (zeroed on bubbles)
//   DATA_W        width of the datapath vector (held on bubbles)
//
// Ports:
//   CLK           clock, all state changes on the rising edge
//   Reset         synchronous, active-high; overrides flush and handshakes
//   flush         drop every held entry on the next edge
//   in_valid      upstream presents an entry
//   in_ready      stage accepts an entry this cycle (registered state only)
//   in_ctrl       upstream control vector
//   in_data       upstream datapath vector
//   out_valid     stage presents an entry
//   out_ready     downstream accepts the presented entry
//   out_ctrl      presented control vector, all-zero when out_valid=0
//   out_data      presented datapath vector
//   occupancy     number of held entries (0, 1 or 2)
//   stall_cycles  saturating stall count (PIPE_STAGE_STATS_EN only)
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [15:0]       stall_cycles
`else
`endif
);

   // The state encoding equals the occupancy count, so the main and skid
   // valid bits are decodes of it: main valid in ONE/TWO, skid valid in TWO.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic main_valid;
   logic in_fire;
   logic out_fire;

   assign main_valid = (state != EMPTY);

   // in_ready depends on registered state only, never on out_ready, so the
   // upstream ready path is cut at this stage.
   assign in_ready  = (state != TWO);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   assign out_valid = main_valid;
   // main_ctrl is already cleared on every path to EMPTY; the mask makes the
   // bubble-is-NOP guarantee independent of that bookkeeping.
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign occupancy = state;

   // NOTE: this register bank resets every field, data included, because the
   // downstream stage must see a fully defined all-zero word after Reset;
   // state uses non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= EMPTY;
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         // Any same-cycle in_fire is dropped; data fields keep their values.
         state     <= EMPTY;
         main_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end else if (in_fire) begin
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
                  state     <= TWO;
               end else if (out_fire) begin
                  main_ctrl <= '0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               // No input can be accepted here, so the skid always drains
               // into main before anything new arrives.
               if (out_fire) begin
                  main_ctrl <= skid_ctrl;
                  main_data <= skid_data;
                  skid_ctrl <= '0;
                  state     <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   // Counts presented-but-refused cycles; saturates, survives flush.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         stall_cycles <= '0;
      end else if (main_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`else
   // Stall statistics not built.
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
//
// Directed and randomized stimulus for pipe_stage. The reference is an
// ordered queue of accepted entries: occupancy is the queue size, the head
// is what the stage presents, flush empties the queue, Reset empties it and
// zeroes the remembered output data.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

   localparam int CW = 8;
   localparam int DW = 128;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } entry_t;

   logic          CLK;
   logic          Reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0]   stall_cycles;
`endif

   pipe_stage #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state
   entry_t        q[$];
   logic [DW-1:0] last_data;
   int            stall_exp;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the model; called mid-cycle (negedge).
   task automatic check_outputs(input string tag);
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      ec = (q.size() > 0) ? q[0].c : '0;
      ed = (q.size() > 0) ? q[0].d : last_data;
      chk({tag, ".occupancy"}, DW'(occupancy), DW'(q.size()));
      chk({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
      chk({tag, ".in_ready"},  DW'(in_ready),  DW'(q.size() < 2));
      chk({tag, ".out_ctrl"},  DW'(out_ctrl),  DW'(ec));
      chk({tag, ".out_data"},  out_data,       ed);
`ifdef PIPE_STAGE_STATS_EN
      chk({tag, ".stall"},     DW'(stall_cycles), DW'(stall_exp));
`endif
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance model
   // at the rising edge. Entered and left just after a rising edge.
   task automatic cycle(input string tag, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic r, input logic f);
      bit in_acc;
      bit out_acc;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(negedge CLK);
      check_outputs(tag);
      in_acc  = v && (q.size() < 2);
      out_acc = (q.size() > 0) && r;
      if ((q.size() > 0) && !r && (stall_exp < 16'hFFFF)) stall_exp++;
      @(posedge CLK);
      #1;
      if (f) begin
         q.delete();
      end else begin
         if (out_acc) void'(q.pop_front());
         if (in_acc) q.push_back('{c: c, d: d});
      end
      if (q.size() > 0) last_data = q[0].d;
   endtask

   task automatic do_reset(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      Reset     = 1'b1;
      @(posedge CLK);
      #1;
      Reset     = 1'b0;
      q.delete();
      last_data = '0;
      stall_exp = 0;
      @(negedge CLK);
      check_outputs(tag);
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      Reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      q.delete();
      last_data = '0;
      stall_exp = 0;
      repeat (2) @(posedge CLK);
      #1;
      do_reset("reset_initial");

      // Reset mid-stream from TWO: everything, including data, goes to zero.
      cycle("fill_a5", 1'b1, 8'hA5, 128'h1111, 1'b0, 1'b0);
      cycle("fill_5a", 1'b1, 8'h5A, 128'h2222, 1'b0, 1'b0);
      cycle("in_two",  1'b0, 8'h00, 128'h0,    1'b0, 1'b0);
      do_reset("reset_mid");

      // Streaming: eight back-to-back entries, one-cycle latency.
      for (int i = 0; i < 8; i++)
         cycle("stream", 1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0);
      cycle("stream_drain", 1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
      cycle("stream_idle",  1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

      // Backpressure: D1,D2 absorbed, D3 held upstream, then in-order drain.
      cycle("bp_d1", 1'b1, 8'h11, 128'hD1, 1'b0, 1'b0);
      cycle("bp_d2", 1'b1, 8'h22, 128'hD2, 1'b0, 1'b0);
      cycle("bp_d3_held", 1'b1, 8'h33, 128'hD3, 1'b0, 1'b0);
      cycle("bp_release1", 1'b1, 8'h33, 128'hD3, 1'b1, 1'b0);
      cycle("bp_release2", 1'b1, 8'h33, 128'hD3, 1'b1, 1'b0);
      cycle("bp_release3", 1'b0, 8'h00, 128'h0,  1'b1, 1'b0);
      cycle("bp_empty",    1'b0, 8'h00, 128'h0,  1'b1, 1'b0);

      // Flush colliding with an incoming entry while in TWO.
      cycle("fl_a", 1'b1, 8'h41, 128'hA1, 1'b0, 1'b0);
      cycle("fl_b", 1'b1, 8'h42, 128'hA2, 1'b0, 1'b0);
      cycle("fl_hit", 1'b1, 8'h43, 128'hA3, 1'b0, 1'b1);
      cycle("fl_after", 1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
      cycle("fl_quiet", 1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

      // Bubble zeroing: ctrl FF drained, ctrl returns to 0, data holds.
      cycle("bub_load",  1'b1, 8'hFF, 128'hBEEF, 1'b1, 1'b0);
      cycle("bub_drain", 1'b0, 8'h00, 128'h0,    1'b1, 1'b0);
      cycle("bub_empty", 1'b0, 8'h00, 128'h0,    1'b1, 1'b0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         cycle("rand", 1'($urandom_range(0, 3) != 0), CW'($urandom), rnd_data(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      do_reset("reset_after_rand");

`ifdef PIPE_STAGE_STATS_EN
      // Saturating stall counter, flush keeps it, Reset clears it.
      cycle("st_load", 1'b1, 8'h77, 128'h7777, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++)
         cycle("st_hold", 1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
      chk("st_saturated", DW'(stall_cycles), DW'(16'hFFFF));
      cycle("st_flush", 1'b0, 8'h00, 128'h0, 1'b1, 1'b1);
      cycle("st_after_flush", 1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
      do_reset("st_reset");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
